core_pipelined: RTL and testbench
=================================

# core_pipelined

Parametrised next-generation compute core for the skein search array. It selects its operand from the broadcast bus, its own core ID, RAM, or a new local accumulator, and executes it through a pipelined ALU of configurable depth. Results are held until the controller accepts them with a valid/ready handshake. It sits in the same array slot as the current core, and its core selection adds a broadcast ID.

## Interface
- `CORE_ID`, default 0: this core's ID, compared against the selection word.
- `ID_W`, default 24: width of core ID and selection field.
- `DATA_W`, default 64: datapath width; must be at least `ID_W` and at least `RAM_W`.
- `RAM_W`, default 16: RAM port width.
- `ALU_STAGES`, default 2: ALU pipeline depth, 1 or more.
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `ram_i`, in, `RAM_W`: RAM read data.
- `input_i`, in, `DATA_W`: broadcast operand bus; the selection word is `[ID_W-1:0]`.
- `save_selection_i`, in, 1: latch the core selection from `input_i`.
- `output_enable_i`, in, 1: drive request for `output_o`.
- `input_select_i`, in, 2: operand source; 0 = `input_i`, 1 = core ID, 2 = `ram_i`, 3 = accumulator.
- `alu_opcode_i`, in, 4: ALU operation.
- `op_valid_i`, in, 1: issue the operation.
- `output_select_i`, in, 1: output source; 0 = `ram_i`, 1 = result register.
- `result_ready_i`, in, 1: controller accepts the result.
- `busy_o`, out, 1: state is not IDLE.
- `result_valid_o`, out, 1: the result register holds an unaccepted result.
- `ram_o`, out, `RAM_W`: low `RAM_W` bits of the output mux.
- `output_o`, out, `DATA_W`: output mux value when the core is selected and enabled, else 0.

## Operation
- Selection:
  - On `save_selection_i`, `selected` is set to 1 if `input_i[ID_W-1:0]` equals `CORE_ID` or the all-ones broadcast ID, else 0.
  - Selection updates in any state.
- Operand widening: the core ID and `ram_i` are zero-extended to `DATA_W`.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE to EXEC when `op_valid_i` and `selected`. Operand, opcode and accumulator snapshot are registered on this edge.
  - `op_valid_i` is ignored outside IDLE or when unselected; operations are never queued.
  - EXEC: a stage counter runs to `ALU_STAGES`, then the FSM moves to HOLD with the result loaded and `result_valid_o` = 1.
  - HOLD to IDLE on `result_ready_i`. The accumulator is written with the result on that same edge.
- Opcodes (A = accumulator snapshot, B = operand):
  - 0 PASS: B.
  - 1 ADD: A+B, wraps modulo 2^`DATA_W`.
  - 2 XOR: A^B.
  - 3 AND: A&B.
  - 4 OR: A|B.
  - 5 ROTL: A rotated left by `B[$clog2(DATA_W)-1:0]`.
  - 6 LOAD: B.
  - 7 POPCNT: population count of A^B, zero-extended (Hamming distance).
  - 8 to 15: B.
- Output gating:
  - `output_o` = (`selected` and `output_enable_i`) ? mux : 0.
  - `ram_o` is ungated.
- A selection change during EXEC or HOLD does not abort the operation; `result_valid_o` is not gated by selection.

## Timing
- Reset values: state IDLE, `selected` 0, accumulator 0, result 0, `busy_o` 0, `result_valid_o` 0, `output_o` 0, `ram_o` 0 when `ram_i` is 0 and `output_select_i` is 0.
- Issue accepted at edge t gives `result_valid_o` high from edge t+`ALU_STAGES`.
- `busy_o` is high from t+1 until the cycle after the handshake.
- If `result_ready_i` is already high when valid rises, the handshake completes at the first HOLD edge; minimum back-to-back issue interval is `ALU_STAGES`+2 cycles.
- In HOLD, `result_valid_o` and the result stay stable until the handshake.
- Reset mid-EXEC or mid-HOLD drops the operation and returns all state to reset values on that edge.
- `save_selection_i` and `op_valid_i` in the same cycle: issue uses the pre-edge `selected`.
- `output_o`, `ram_o` and the mux are combinational from registers and inputs; no added latency.

## Structure
- Shared package `core_pkg`:
  - opcode localparams
  - input-select codes
  - FSM state typedef
  - broadcast ID (all ones, `ID_W` bits)
- One sub-module, `alu_pipe`: opcode decode plus `ALU_STAGES` register stages. The FSM, selection logic, accumulator and muxes stay at the top.

## Test plan
- Reset, then `CORE_ID`=5 and selection 5 -> `selected`=1. Selection 6 -> 0. Selection 0xFFFFFF -> 1.
- LOAD with B=0x10, then ADD with B=0xFFFF_FFFF_FFFF_FFF8, `ALU_STAGES`=2, ready held high -> results 0x10 then 0x8; valid rises exactly 2 cycles after each issue.
- POPCNT with A=0xFF, B=0x0F -> result 4. ROTL with A=0x8000_0000_0000_0001, B=1 -> 0x3.
- Hold ready low 5 cycles in HOLD -> result stable, `busy_o`=1, a second `op_valid_i` is ignored. Ready high -> IDLE next cycle, accumulator updated.
- Unselected core: `op_valid_i` -> no state change. `output_enable_i`=1 -> `output_o`=0.
- Assert `rst_i` during EXEC -> next cycle valid 0, busy 0, accumulator 0; a later issue proceeds normally.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : core_pkg                                                     |
// | Description : Shared constants and types for the pipelined skein core:     |
// |               ALU opcodes, operand-select codes, FSM state type and the    |
// |               all-ones broadcast core ID.                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package core_pkg;

   // ALU opcodes; 8..15 fall through to PASS behaviour.
   localparam logic [3:0] OP_PASS   = 4'd0;
   localparam logic [3:0] OP_ADD    = 4'd1;
   localparam logic [3:0] OP_XOR    = 4'd2;
   localparam logic [3:0] OP_AND    = 4'd3;
   localparam logic [3:0] OP_OR     = 4'd4;
   localparam logic [3:0] OP_ROTL   = 4'd5;
   localparam logic [3:0] OP_LOAD   = 4'd6;
   localparam logic [3:0] OP_POPCNT = 4'd7;

   // Operand source select codes.
   localparam logic [1:0] SEL_INPUT   = 2'd0;
   localparam logic [1:0] SEL_CORE_ID = 2'd1;
   localparam logic [1:0] SEL_RAM     = 2'd2;
   localparam logic [1:0] SEL_ACC     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // All-ones broadcast ID; users slice off the low ID_W bits (ID_W <= 64).
   localparam logic [63:0] BROADCAST_ID = '1;

endpackage
`default_nettype wire

// File: rtl/core_pipelined_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pipe                                                     |
// | Description : Opcode decode and ALU with ALU_STAGES register stages.       |
// |               Stage 1 captures opcode/A/B on i_issue; the remaining        |
// |               ALU_STAGES-1 stages delay the evaluated result. o_result is  |
// |               valid ALU_STAGES-1 edges after the issue edge.               |
// | Ports       : clk, rst (sync, active-high), i_issue (capture strobe),      |
// |               i_opcode, i_a (accumulator snapshot), i_b (operand),         |
// |               o_result (pipelined result).                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_pipe
   import core_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int ALU_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_issue,
   input  logic [3:0]        i_opcode,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_result
);

   localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [3:0]        r_opcode;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] w_eval;

   function automatic logic [DATA_W-1:0] alu_eval(
      input logic [3:0]        op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic [2*DATA_W-1:0] dbl;
      logic [SH_W-1:0]     sh;
      logic [DATA_W-1:0]   diff;
      logic [DATA_W-1:0]   cnt;
      logic [DATA_W-1:0]   res;
      sh   = b[SH_W-1:0];
      diff = a ^ b;
      cnt  = '0;
      res  = b;
      case (op)
         OP_PASS, OP_LOAD: res = b;
         OP_ADD:           res = a + b;
         OP_XOR:           res = a ^ b;
         OP_AND:           res = a & b;
         OP_OR:            res = a | b;
         OP_ROTL: begin
            // Rotate by shifting a doubled copy; the upper half is the result.
            dbl = {a, a} << sh;
            res = dbl[2*DATA_W-1:DATA_W];
         end
         OP_POPCNT: begin
            for (int i = 0; i < DATA_W; i++) begin
               cnt = cnt + DATA_W'(diff[i]);
            end
            res = cnt;
         end
         default:          res = b;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opcode <= OP_PASS;
         r_a      <= '0;
         r_b      <= '0;
      end else if (i_issue) begin
         r_opcode <= i_opcode;
         r_a      <= i_a;
         r_b      <= i_b;
      end
   end

   assign w_eval = alu_eval(r_opcode, r_a, r_b);

   generate
      if (ALU_STAGES == 1) begin : g_direct
         assign o_result = w_eval;
      end else begin : g_stages
         logic [DATA_W-1:0] r_stage [ALU_STAGES-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < ALU_STAGES-1; i++) begin
                  r_stage[i] <= '0;
               end
            end else begin
               r_stage[0] <= w_eval;
               for (int i = 1; i < ALU_STAGES-1; i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign o_result = r_stage[ALU_STAGES-2];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/core_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_pipelined                                               |
// | Description : Skein search-array compute core. Selects an operand (bus,    |
// |               core ID, RAM or accumulator), runs it through a pipelined    |
// |               ALU and holds the result until a valid/ready handshake,      |
// |               which also writes the accumulator.                           |
// | Ports       : clk_i, rst_i (sync, active-high); ram_i, input_i operands;   |
// |               save_selection_i, output_enable_i, input_select_i,           |
// |               alu_opcode_i, op_valid_i, output_select_i, result_ready_i    |
// |               controls; busy_o, result_valid_o status; ram_o, output_o.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module core_pipelined
   import core_pkg::*;
#(
   parameter int CORE_ID    = 0,
   parameter int ID_W       = 24,
   parameter int DATA_W     = 64,
   parameter int RAM_W      = 16,
   parameter int ALU_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [RAM_W-1:0]  ram_i,
   input  logic [DATA_W-1:0] input_i,
   input  logic              save_selection_i,
   input  logic              output_enable_i,
   input  logic [1:0]        input_select_i,
   input  logic [3:0]        alu_opcode_i,
   input  logic              op_valid_i,
   input  logic              output_select_i,
   input  logic              result_ready_i,
   output logic              busy_o,
   output logic              result_valid_o,
   output logic [RAM_W-1:0]  ram_o,
   output logic [DATA_W-1:0] output_o
);

   localparam int                CNT_W     = $clog2(ALU_STAGES + 1);
   localparam logic [ID_W-1:0]   c_core_id = ID_W'(CORE_ID);
   localparam logic [ID_W-1:0]   c_bcast   = BROADCAST_ID[ID_W-1:0];
   localparam logic [CNT_W-1:0]  c_last    = CNT_W'(ALU_STAGES - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic              r_selected;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_result;
   logic              w_issue;
   logic              w_accept;
   logic              w_exec_done;
   logic [DATA_W-1:0] w_operand;
   logic [DATA_W-1:0] w_alu_out;
   logic [DATA_W-1:0] w_mux;

   // Operand source; core ID and RAM data are zero-extended.
   always_comb begin
      w_operand = input_i;
      case (input_select_i)
         SEL_INPUT:   w_operand = input_i;
         SEL_CORE_ID: w_operand = DATA_W'(c_core_id);
         SEL_RAM:     w_operand = DATA_W'(ram_i);
         SEL_ACC:     w_operand = r_acc;
         default:     w_operand = input_i;
      endcase
   end

   alu_pipe #(
      .DATA_W     (DATA_W),
      .ALU_STAGES (ALU_STAGES)
   ) u_alu_pipe (
      .clk      (clk_i),
      .rst      (rst_i),
      .i_issue  (w_issue),
      .i_opcode (alu_opcode_i),
      .i_a      (r_acc),
      .i_b      (w_operand),
      .o_result (w_alu_out)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Issue uses the pre-edge selection, so a same-cycle save does not count.
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_accept     = 1'b0;
      w_exec_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (op_valid_i && r_selected) begin
               w_issue      = 1'b1;
               w_state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (r_cnt == c_last) begin
               w_exec_done  = 1'b1;
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (result_ready_i) begin
               w_accept     = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_selected <= 1'b0;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_result   <= '0;
      end else begin
         if (save_selection_i) begin
            r_selected <= (input_i[ID_W-1:0] == c_core_id) ||
                          (input_i[ID_W-1:0] == c_bcast);
         end
         if (w_issue) begin
            r_cnt <= '0;
         end else if (r_state == ST_EXEC) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_exec_done) begin
            r_result <= w_alu_out;
         end
         if (w_accept) begin
            r_acc <= r_result;
         end
      end
   end

   assign busy_o         = (r_state != ST_IDLE);
   assign result_valid_o = (r_state == ST_HOLD);
   assign w_mux          = output_select_i ? r_result : DATA_W'(ram_i);
   assign ram_o          = w_mux[RAM_W-1:0];
   assign output_o       = (r_selected && output_enable_i) ? w_mux : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_core_pipelined                                            |
// | Description : Directed self-checking bench for core_pipelined with         |
// |               CORE_ID=5, ID_W=24, DATA_W=64, RAM_W=16, ALU_STAGES=2.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_core_pipelined;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ram_i;
   logic [63:0] input_i;
   logic        save_selection;
   logic        output_enable;
   logic [1:0]  input_select;
   logic [3:0]  alu_opcode;
   logic        op_valid;
   logic        output_select;
   logic        result_ready;
   logic        busy;
   logic        result_valid;
   logic [15:0] ram_o;
   logic [63:0] output_o;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   core_pipelined #(
      .CORE_ID    (5),
      .ID_W       (24),
      .DATA_W     (64),
      .RAM_W      (16),
      .ALU_STAGES (2)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .ram_i            (ram_i),
      .input_i          (input_i),
      .save_selection_i (save_selection),
      .output_enable_i  (output_enable),
      .input_select_i   (input_select),
      .alu_opcode_i     (alu_opcode),
      .op_valid_i       (op_valid),
      .output_select_i  (output_select),
      .result_ready_i   (result_ready),
      .busy_o           (busy),
      .result_valid_o   (result_valid),
      .ram_o            (ram_o),
      .output_o         (output_o)
   );

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic save_sel(input logic [23:0] id);
      input_i        = {40'h0, id};
      save_selection = 1'b1;
      @(negedge clk);
      save_selection = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] sel, input logic [63:0] b);
      alu_opcode   = op;
      input_select = sel;
      input_i      = b;
      op_valid     = 1'b1;
      @(negedge clk);
      op_valid     = 1'b0;
   endtask

   // Cycles from the issue edge until result_valid_o; 20 means it never rose.
   task automatic wait_valid(output int n);
      n = 0;
      while (!result_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; ram_i = '0; input_i = '0; save_selection = 1'b0;
      output_enable = 1'b1; input_select = '0; alu_opcode = '0;
      op_valid = 1'b0; output_select = 1'b0; result_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", result_valid); end
      vectors++; if (output_o !== 64'h0) begin miscompares++; $display("FAIL reset_output: got %h want 0", output_o); end
      vectors++; if (ram_o !== 16'h0) begin miscompares++; $display("FAIL reset_ram_o: got %h want 0", ram_o); end
      output_select = 1'b1;
      #1;
      vectors++; if (ram_o !== 16'h0) begin miscompares++; $display("FAIL reset_result: got %h want 0", ram_o); end
      output_select = 1'b0;
   endtask

   task automatic test_selection;
      ram_i = 16'h1234; output_select = 1'b0; output_enable = 1'b1;
      save_sel(24'h000005);
      vectors++; if (output_o !== 64'h1234) begin miscompares++; $display("FAIL sel_own_id: got %h want 1234", output_o); end
      save_sel(24'h000006);
      vectors++; if (output_o !== 64'h0) begin miscompares++; $display("FAIL sel_other_id: got %h want 0", output_o); end
      save_sel(24'hFFFFFF);
      vectors++; if (output_o !== 64'h1234) begin miscompares++; $display("FAIL sel_broadcast: got %h want 1234", output_o); end
      save_sel(24'h000005);
   endtask

   task automatic test_load_add;
      int n;
      result_ready = 1'b1; output_select = 1'b1;
      issue(OP_LOAD, SEL_INPUT, 64'h10);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy: got %b want 1", busy); end
      wait_valid(n);
      vectors++; if (n != 2) begin miscompares++; $display("FAIL load_latency: got %0d want 2", n); end
      vectors++; if (output_o !== 64'h10) begin miscompares++; $display("FAIL load_result: got %h want 10", output_o); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL load_idle: got %b want 0", busy); end
      issue(OP_ADD, SEL_INPUT, 64'hFFFF_FFFF_FFFF_FFF8);
      wait_valid(n);
      vectors++; if (n != 2) begin miscompares++; $display("FAIL add_latency: got %0d want 2", n); end
      vectors++; if (output_o !== 64'h8) begin miscompares++; $display("FAIL add_wrap: got %h want 8", output_o); end
      @(negedge clk);
   endtask

   task automatic test_popcnt_rotl;
      int n;
      issue(OP_LOAD, SEL_INPUT, 64'hFF); wait_valid(n); @(negedge clk);
      issue(OP_POPCNT, SEL_INPUT, 64'h0F); wait_valid(n);
      vectors++; if (output_o !== 64'h4) begin miscompares++; $display("FAIL popcnt: got %h want 4", output_o); end
      @(negedge clk);
      issue(OP_LOAD, SEL_INPUT, 64'h8000_0000_0000_0001); wait_valid(n); @(negedge clk);
      issue(OP_ROTL, SEL_INPUT, 64'h1); wait_valid(n);
      vectors++; if (output_o !== 64'h3) begin miscompares++; $display("FAIL rotl: got %h want 3", output_o); end
      @(negedge clk);
      issue(OP_XOR, SEL_INPUT, 64'hF0F0); wait_valid(n);
      vectors++; if (output_o !== 64'hF0F3) begin miscompares++; $display("FAIL xor: got %h want f0f3", output_o); end
      @(negedge clk);
   endtask

   task automatic test_hold;
      int n;
      result_ready = 1'b0; ram_i = 16'h0055;
      issue(OP_PASS, SEL_RAM, 64'hDEAD);
      wait_valid(n);
      vectors++; if (n != 2) begin miscompares++; $display("FAIL hold_latency: got %0d want 2", n); end
      for (int i = 0; i < 5; i++) begin
         op_valid = (i == 0); alu_opcode = OP_ADD; input_select = SEL_INPUT; input_i = 64'h7;
         @(negedge clk);
         op_valid = 1'b0;
         vectors++; if (output_o !== 64'h55 || result_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL hold_stable[%0d]: got out=%h valid=%b busy=%b want 55/1/1", i, output_o, result_valid, busy);
         end
      end
      result_ready = 1'b1;
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: got busy=%b valid=%b want 0/0", busy, result_valid); end
      issue(OP_PASS, SEL_ACC, 64'h0); wait_valid(n);
      vectors++; if (output_o !== 64'h55) begin miscompares++; $display("FAIL acc_written: got %h want 55", output_o); end
      @(negedge clk);
      issue(OP_PASS, SEL_CORE_ID, 64'h0); wait_valid(n);
      vectors++; if (output_o !== 64'h5) begin miscompares++; $display("FAIL core_id_operand: got %h want 5", output_o); end
      @(negedge clk);
   endtask

   task automatic test_unselected;
      save_sel(24'h000006);
      issue(OP_LOAD, SEL_INPUT, 64'h99);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL unsel_busy: got %b want 0", busy); end
      repeat (3) @(negedge clk);
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL unsel_valid: got %b want 0", result_valid); end
      output_enable = 1'b1; output_select = 1'b0; ram_i = 16'hBEEF;
      #1;
      vectors++; if (output_o !== 64'h0) begin miscompares++; $display("FAIL unsel_output: got %h want 0", output_o); end
      vectors++; if (ram_o !== 16'hBEEF) begin miscompares++; $display("FAIL ram_o_ungated: got %h want beef", ram_o); end
   endtask

   task automatic test_reset_exec;
      int n;
      save_sel(24'h000005);
      output_select = 1'b1; result_ready = 1'b1;
      issue(OP_ADD, SEL_INPUT, 64'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (busy !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL rst_exec: got busy=%b valid=%b want 0/0", busy, result_valid); end
      @(negedge clk);
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL rst_exec_stays_idle: got %b want 0", result_valid); end
      save_sel(24'h000005);
      issue(OP_PASS, SEL_ACC, 64'h0); wait_valid(n);
      vectors++; if (n != 2) begin miscompares++; $display("FAIL rst_reissue_latency: got %0d want 2", n); end
      vectors++; if (output_o !== 64'h0) begin miscompares++; $display("FAIL rst_acc_cleared: got %h want 0", output_o); end
      @(negedge clk);
      issue(OP_ADD, SEL_INPUT, 64'h7); wait_valid(n);
      vectors++; if (output_o !== 64'h7) begin miscompares++; $display("FAIL rst_then_add: got %h want 7", output_o); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_selection();
      test_load_add();
      test_popcnt_rotl();
      test_hold();
      test_unselected();
      test_reset_exec();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
